memory_read_responder: RTL and testbench
========================================

// Module: memory_read_responder
// PURPOSE
//  Target end of memory_read_iface: serves instruction-memory reads issued by the round-robin
//  memory arbiter of the engine mesh (basic blocks + central controller).
//  One request in flight: pulses ready with data for the granted requester.
//  Echoes the served word on broadcast_addr/broadcast_valid so BB caches can snoop it.
//  Owns the program RAM and its host write (load) port.
// PARAMETERS
//  MEMORY_WIDTH       16  data word width (bits)
//  MEMORY_ADDR_WIDTH  11  word address width; depth = 2**MEMORY_ADDR_WIDTH
//  READ_LATENCY       2   cycles from request accept to response, legal 1..4
//  STAT_WIDTH         32  width of statistics counters (macro feature only)
// PORTS
//  clk              in   1      clock
//  rst              in   1      asynchronous reset, active-high
//  memory           memory_read_iface.in  fields: valid,addr (in); ready,data,broadcast_addr,broadcast_valid (out)
//  wr_en            in   1      host program-load write strobe
//  wr_addr          in   MEMORY_ADDR_WIDTH  write address
//  wr_data          in   MEMORY_WIDTH       write data
//  busy             out  1      request in flight (state != IDLE)
//  stat_reads       out  STAT_WIDTH  completed reads (macro feature)
//  stat_wait_cycles out  STAT_WIDTH  cycles memory.valid high with ready low (macro feature)
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE, ready=0, broadcast_valid=0, data/broadcast_addr=0,
//    latency counter=0, stats=0. RAM contents NOT reset. Reset mid-read drops the request, no response.
//  - Requester holds valid and addr stable until it sees ready=1 (one-cycle pulse).
//  - FSM: IDLE -> WAIT -> RESP -> IDLE.
//    IDLE: if memory.valid && !wr_en: latch addr, issue RAM read, cnt=READ_LATENCY-1;
//          -> RESP if READ_LATENCY==1, else -> WAIT. wr_en high: stay IDLE (write has priority).
//    WAIT: cnt decrements each cycle; cnt==1 -> RESP.
//    RESP: ready=1, data=word, broadcast_valid=1, broadcast_addr=latched addr, all for exactly 1 cycle; -> IDLE.
//  - Total latency: valid sampled in cycle t -> ready high in cycle t+READ_LATENCY.
//  - Mandatory IDLE cycle after RESP: back-to-back reads spaced READ_LATENCY+1 cycles, so the arbiter
//    sees ready drop and can rotate grant.
//  - Write forwarding: wr_en to latched addr during WAIT/RESP-setup -> response returns wr_data
//    (last write wins). Writes to other addresses do not affect the in-flight read.
//  - wr_en is accepted in every state (RAM write port independent); read is deferred only in IDLE.
//  - data/broadcast_addr hold last value outside RESP; consumers qualify with ready/broadcast_valid.
//  - memory.valid dropped mid-flight (protocol violation): response still issued, no hang.
//  - Address wrap: none needed; addr is exactly MEMORY_ADDR_WIDTH bits.
// CONFIGURATION
//  MEM_RESP_STATS_EN defined: stat_reads +1 per RESP cycle; stat_wait_cycles +1 per cycle with
//   valid=1 && ready=0; both saturate at all-ones.
//  Not defined: counters absent, stat_* tied to 0; timing identical.
// STRUCTURE
//  Package memory_responder_pkg: typedef enum logic[1:0] {IDLE,WAIT,RESP} resp_state_t;
//   localparam READ_LATENCY_MAX=4; counter width $clog2(READ_LATENCY_MAX+1).
//  Sub-module ram_sdp: simple dual-port RAM, 1 write port, 1 read port, READ_LATENCY-1 output
//   pipeline stages after a registered read; the responder holds FSM, forwarding and stats.
// TESTING
//  1 Preload addr 0x005=0xBEEF; valid=1,addr=0x005 at t0 (LAT=2) -> ready=1,data=0xBEEF,
//    broadcast_addr=0x005,broadcast_valid=1 at t0+2 only.
//  2 valid held continuously on 0x001,0x002 -> responses at t0+2 and t0+5; ready low between.
//  3 Read 0x010 in flight, wr_en to 0x010 with 0x1234 in WAIT -> response data=0x1234;
//    write to 0x011 instead -> old 0x010 value.
//  4 wr_en high while valid arrives in IDLE -> read starts cycle after wr_en drops; latency counts from there.
//  5 rst asserted during WAIT -> ready/broadcast_valid 0 immediately; RAM keeps 0xBEEF; next read served normally.
//  6 MEM_RESP_STATS_EN, LAT=1, 3 reads -> stat_reads=3, stat_wait_cycles=3; LAT=4 sweep checks t0+4.

Source files
------------

// File: rtl/memory_responder_pkg.sv
// ============================================================================
// Module  : memory_responder_pkg
// Brief   : Shared types and constants for the instruction-memory read responder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package memory_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_t;

    localparam int READ_LATENCY_MAX = 4;
    localparam int CNT_WIDTH        = $clog2(READ_LATENCY_MAX + 1);

endpackage

`default_nettype wire

// File: rtl/memory_read_iface.sv
// ============================================================================
// Module  : memory_read_iface
// Brief   : Arbiter-to-memory read channel with snoop broadcast of served words.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface memory_read_iface #(
    parameter int MEMORY_WIDTH      = 16,
    parameter int MEMORY_ADDR_WIDTH = 11
);
    logic                         valid;
    logic [MEMORY_ADDR_WIDTH-1:0] addr;
    logic                         ready;
    logic [MEMORY_WIDTH-1:0]      data;
    logic [MEMORY_ADDR_WIDTH-1:0] broadcast_addr;
    logic                         broadcast_valid;

    modport in  (input  valid, addr, output ready, data, broadcast_addr, broadcast_valid);
    modport out (output valid, addr, input  ready, data, broadcast_addr, broadcast_valid);
endinterface

`default_nettype wire

// File: rtl/ram_sdp.sv
// ============================================================================
// Module  : ram_sdp
// Brief   : Simple dual-port RAM, registered read followed by LATENCY-1 stages.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_sdp #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 11,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [WIDTH-1:0] rd_q;

    // Contents are intentionally not reset so a program load survives rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_q <= mem_q[rd_addr];
        end
    end

    generate
        if (LATENCY > 1) begin : g_pipe
            logic [WIDTH-1:0] pipe_q [LATENCY-1];

            always_ff @(posedge clk) begin
                pipe_q[0] <= rd_q;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end

            assign rd_data = pipe_q[LATENCY-2];
        end else begin : g_no_pipe
            assign rd_data = rd_q;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/memory_read_responder.sv
// ============================================================================
// Module  : memory_read_responder
// Brief   : Serves one in-flight instruction-memory read with write forwarding
//           and snoop broadcast. Optional counters under MEM_RESP_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_read_responder
    import memory_responder_pkg::*;
#(
    parameter int MEMORY_WIDTH      = 16,
    parameter int MEMORY_ADDR_WIDTH = 11,
    parameter int READ_LATENCY      = 2,
    parameter int STAT_WIDTH        = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    memory_read_iface.in                 memory,
    input  logic                         wr_en,
    input  logic [MEMORY_ADDR_WIDTH-1:0] wr_addr,
    input  logic [MEMORY_WIDTH-1:0]      wr_data,
    output logic                         busy,
    output logic [STAT_WIDTH-1:0]        stat_reads,
    output logic [STAT_WIDTH-1:0]        stat_wait_cycles
);

    localparam logic [CNT_WIDTH-1:0] c_cnt_init = CNT_WIDTH'(READ_LATENCY - 1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);

    resp_state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
    logic [MEMORY_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                         fwd_valid_q, fwd_valid_d;
    logic [MEMORY_WIDTH-1:0]      fwd_data_q, fwd_data_d;
    logic [MEMORY_WIDTH-1:0]      data_hold_q, data_hold_d;
    logic [MEMORY_ADDR_WIDTH-1:0] baddr_hold_q, baddr_hold_d;

    logic                         w_accept;
    logic                         w_resp;
    logic [MEMORY_WIDTH-1:0]      w_ram_data;
    logic [MEMORY_WIDTH-1:0]      w_word;

    // A host write in the same cycle defers the read by keeping the FSM in IDLE.
    assign w_accept = (state_q == IDLE) && memory.valid && !wr_en;
    assign w_resp   = (state_q == RESP);
    assign w_word   = fwd_valid_q ? fwd_data_q : w_ram_data;

    ram_sdp #(
        .WIDTH     (MEMORY_WIDTH),
        .ADDR_WIDTH(MEMORY_ADDR_WIDTH),
        .LATENCY   (READ_LATENCY)
    ) u_ram (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_en  (w_accept),
        .rd_addr(memory.addr),
        .rd_data(w_ram_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            fwd_valid_q  <= 1'b0;
            fwd_data_q   <= '0;
            data_hold_q  <= '0;
            baddr_hold_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            fwd_valid_q  <= fwd_valid_d;
            fwd_data_q   <= fwd_data_d;
            data_hold_q  <= data_hold_d;
            baddr_hold_q <= baddr_hold_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        fwd_valid_d  = fwd_valid_q;
        fwd_data_d   = fwd_data_q;
        data_hold_d  = data_hold_q;
        baddr_hold_d = baddr_hold_q;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    addr_d      = memory.addr;
                    cnt_d       = c_cnt_init;
                    fwd_valid_d = 1'b0;
                    state_d     = (READ_LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - c_cnt_one;
                if (cnt_q == c_cnt_one) begin
                    state_d = RESP;
                end
                // The RAM read already left; capture same-address writes so the newest data wins.
                if (wr_en && (wr_addr == addr_q)) begin
                    fwd_valid_d = 1'b1;
                    fwd_data_d  = wr_data;
                end
            end
            RESP: begin
                state_d      = IDLE;
                data_hold_d  = w_word;
                baddr_hold_d = addr_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        memory.ready           = w_resp;
        memory.broadcast_valid = w_resp;
        memory.data            = w_resp ? w_word : data_hold_q;
        memory.broadcast_addr  = w_resp ? addr_q : baddr_hold_q;
        busy                   = (state_q != IDLE);
    end

`ifdef MEM_RESP_STATS_EN
    logic [STAT_WIDTH-1:0] stat_reads_q, stat_reads_d;
    logic [STAT_WIDTH-1:0] stat_wait_q, stat_wait_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_reads_q <= '0;
            stat_wait_q  <= '0;
        end else begin
            stat_reads_q <= stat_reads_d;
            stat_wait_q  <= stat_wait_d;
        end
    end

    always_comb begin
        stat_reads_d = stat_reads_q;
        stat_wait_d  = stat_wait_q;
        if (w_resp && (stat_reads_q != '1)) begin
            stat_reads_d = stat_reads_q + STAT_WIDTH'(1);
        end
        if (memory.valid && !w_resp && (stat_wait_q != '1)) begin
            stat_wait_d = stat_wait_q + STAT_WIDTH'(1);
        end
    end

    assign stat_reads       = stat_reads_q;
    assign stat_wait_cycles = stat_wait_q;
`else
    assign stat_reads       = '0;
    assign stat_wait_cycles = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_memory_read_responder.sv
// ============================================================================
// Module  : tb_memory_read_responder
// Brief   : Directed self-checking bench for latency 2 (main), 1 and 4 builds.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_read_responder;

    logic        clk;
    logic        rst;
    logic        v1, v2, v4;
    logic [10:0] addr;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [15:0] wr_data;
    logic        busy1, busy2, busy4;
    logic [31:0] sr1, sw1, sr2, sw2, sr4, sw4;

    int n_checks = 0;
    int n_errors = 0;

    memory_read_iface #(.MEMORY_WIDTH(16), .MEMORY_ADDR_WIDTH(11)) if1 ();
    memory_read_iface #(.MEMORY_WIDTH(16), .MEMORY_ADDR_WIDTH(11)) if2 ();
    memory_read_iface #(.MEMORY_WIDTH(16), .MEMORY_ADDR_WIDTH(11)) if4 ();

    assign if1.valid = v1;
    assign if2.valid = v2;
    assign if4.valid = v4;
    assign if1.addr  = addr;
    assign if2.addr  = addr;
    assign if4.addr  = addr;

    memory_read_responder #(.READ_LATENCY(2)) u_dut2 (
        .clk(clk), .rst(rst), .memory(if2), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy2), .stat_reads(sr2), .stat_wait_cycles(sw2)
    );
    memory_read_responder #(.READ_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .memory(if1), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy1), .stat_reads(sr1), .stat_wait_cycles(sw1)
    );
    memory_read_responder #(.READ_LATENCY(4)) u_dut4 (
        .clk(clk), .rst(rst), .memory(if4), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy4), .stat_reads(sr4), .stat_wait_cycles(sw4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [10:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; v1 = 1'b0; v2 = 1'b0; v4 = 1'b0; addr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        #2;
        check("rst_ready",  if2.ready, 0);
        check("rst_bvalid", if2.broadcast_valid, 0);
        check("rst_data",   if2.data, 0);
        check("rst_baddr",  if2.broadcast_addr, 0);
        check("rst_busy",   busy2, 0);
        tick(); tick();
        rst = 1'b0;
        wr(11'h005, 16'hBEEF); wr(11'h001, 16'h1111);
        wr(11'h002, 16'h2222); wr(11'h010, 16'hAAAA);

        // Basic read, response exactly two cycles after request
        v2 = 1'b1; addr = 11'h005;
        tick(); check("t1_c1_ready", if2.ready, 0); check("t1_c1_busy", busy2, 1);
        tick();
        check("t1_ready", if2.ready, 1); check("t1_data", if2.data, 16'hBEEF);
        check("t1_baddr", if2.broadcast_addr, 11'h005); check("t1_bvalid", if2.broadcast_valid, 1);
        v2 = 1'b0;
        tick();
        check("t1_c3_ready", if2.ready, 0); check("t1_c3_bvalid", if2.broadcast_valid, 0);
        check("t1_c3_busy", busy2, 0); check("t1_hold_data", if2.data, 16'hBEEF);

        // Back-to-back with valid held: responses at t+2 and t+5
        v2 = 1'b1; addr = 11'h001;
        tick(); check("t2_c1_ready", if2.ready, 0);
        tick(); check("t2_r1_ready", if2.ready, 1); check("t2_r1_data", if2.data, 16'h1111);
        addr = 11'h002;
        tick(); check("t2_c3_ready", if2.ready, 0);
        tick(); check("t2_c4_ready", if2.ready, 0);
        tick(); check("t2_r2_ready", if2.ready, 1); check("t2_r2_data", if2.data, 16'h2222);
        check("t2_r2_baddr", if2.broadcast_addr, 11'h002);
        v2 = 1'b0;
        tick();

        // Write forwarding to the in-flight address
        v2 = 1'b1; addr = 11'h010;
        tick();
        wr_en = 1'b1; wr_addr = 11'h010; wr_data = 16'h1234;
        tick(); wr_en = 1'b0;
        check("t3_fwd_ready", if2.ready, 1); check("t3_fwd_data", if2.data, 16'h1234);
        v2 = 1'b0;
        tick();
        wr(11'h010, 16'hAAAA);
        v2 = 1'b1; addr = 11'h010;
        tick();
        wr_en = 1'b1; wr_addr = 11'h011; wr_data = 16'h5555;
        tick(); wr_en = 1'b0;
        check("t3_nofwd_ready", if2.ready, 1); check("t3_nofwd_data", if2.data, 16'hAAAA);
        v2 = 1'b0;
        tick();

        // Write priority defers the read until wr_en drops
        wr_en = 1'b1; wr_addr = 11'h020; wr_data = 16'h7777;
        v2 = 1'b1; addr = 11'h005;
        tick(); check("t4_c1_busy", busy2, 0);
        tick(); check("t4_c2_busy", busy2, 0); check("t4_c2_ready", if2.ready, 0);
        wr_en = 1'b0;
        tick(); check("t4_c3_busy", busy2, 1); check("t4_c3_ready", if2.ready, 0);
        tick(); check("t4_ready", if2.ready, 1); check("t4_data", if2.data, 16'hBEEF);
        v2 = 1'b0;
        tick();

        // Async reset in WAIT drops the request
        v2 = 1'b1; addr = 11'h005;
        tick(); check("t5_wait_busy", busy2, 1);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_ready", if2.ready, 0); check("t5_rst_bvalid", if2.broadcast_valid, 0);
        check("t5_rst_busy", busy2, 0); check("t5_rst_data", if2.data, 0);
        v2 = 1'b0;
        tick(); rst = 1'b0;
        tick(); check("t5_no_resp", if2.ready, 0);
        v2 = 1'b1; addr = 11'h005;
        tick(); tick();
        check("t5_after_ready", if2.ready, 1); check("t5_after_data", if2.data, 16'hBEEF);
        v2 = 1'b0;
        tick();

        // Latency 1: three reads spaced two cycles
        v1 = 1'b1; addr = 11'h001;
        tick(); check("t6_r1_ready", if1.ready, 1); check("t6_r1_data", if1.data, 16'h1111);
        addr = 11'h002;
        tick(); check("t6_gap1", if1.ready, 0);
        tick(); check("t6_r2_ready", if1.ready, 1); check("t6_r2_data", if1.data, 16'h2222);
        addr = 11'h005;
        tick(); check("t6_gap2", if1.ready, 0);
        tick(); check("t6_r3_ready", if1.ready, 1); check("t6_r3_data", if1.data, 16'hBEEF);
        v1 = 1'b0;
        tick();
`ifdef MEM_RESP_STATS_EN
        check("t6_stat_reads", sr1, 3);
        check("t6_stat_wait",  sw1, 3);
`else
        check("t6_stat_reads", sr1, 0);
        check("t6_stat_wait",  sw1, 0);
`endif

        // Latency 4, then valid dropped mid-flight still completes
        v4 = 1'b1; addr = 11'h005;
        tick(); check("t7_c1_ready", if4.ready, 0);
        tick(); tick(); check("t7_c3_ready", if4.ready, 0);
        tick(); check("t7_ready", if4.ready, 1); check("t7_data", if4.data, 16'hBEEF);
        v4 = 1'b0;
        tick();
        v4 = 1'b1; addr = 11'h001;
        tick(); v4 = 1'b0;
        tick(); tick(); check("t7_drop_c3", if4.ready, 0);
        tick(); check("t7_drop_ready", if4.ready, 1); check("t7_drop_data", if4.data, 16'h1111);
        tick(); check("t7_drop_idle", busy4, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
